mult_arbiter: RTL
=================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one FP32 multiplier.
REQ-002 SHALL have parameter IDW, default 2, requester-ID width, equal to clog2(NREQ).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  NREQ  per-requester operand-pair valid.
REQ-006 req_a  input  32*NREQ  packed IEEE-754 single operands A; requester i occupies bits [32i+31:32i].
REQ-007 req_b  input  32*NREQ  packed operands B; same packing as req_a.
REQ-008 req_ready  output  NREQ  one-hot grant; a bit high means that requester's operands are accepted this cycle.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  32  FP32 product.
REQ-012 out_id  output  IDW  requester index that owns out_data.
REQ-013 out_invalid  output  1  product had a NaN or Inf operand.
REQ-014 invalid_cnt  output  16  saturating count of invalid results handed off.

Function
REQ-015 SHALL implement the FSM states IDLE, CALC and HOLD.
REQ-016 IDLE: if any req_valid bit is set, grant exactly one requester, latch its A, B and ID into operand registers, and go to CALC; otherwise stay in IDLE.
REQ-017 CALC: drive multiplier En=1, register its Out into out_data and its Invalid_Num into out_invalid, set out_valid, and go to HOLD; this state lasts exactly 1 cycle.
REQ-018 HOLD: hold out_valid, out_data, out_id and out_invalid stable while out_ready=0.
REQ-019 HOLD with out_ready=1: complete the handoff; if any req_valid is set, grant in the same cycle and go to CALC, otherwise go to IDLE.
REQ-020 Latency: the result is visible 2 cycles after the grant edge; peak throughput is 1 result per 2 cycles.
REQ-021 Arbitration SHALL be round-robin: search starts at rr_ptr, and after a grant to index k, rr_ptr = (k+1) mod NREQ, wrapping from NREQ-1 to 0.
REQ-022 req_ready SHALL be at most one-hot, and SHALL be 0 in CALC and in HOLD while out_ready=0.
REQ-023 A requester deasserting req_valid before it is granted is legal; it is simply skipped.
REQ-024 Multiplier En SHALL be 0 outside CALC.
REQ-025 The operand registers SHALL change only on a grant.
REQ-026 invalid_cnt SHALL increment on each handoff (out_valid & out_ready) with out_invalid=1, and SHALL saturate at 0xFFFF.
REQ-027 out_valid SHALL be 0 in IDLE and CALC.

Reset
REQ-028 On rst high, asynchronously: state=IDLE, rr_ptr=0, out_valid=0, out_data=0, out_id=0, out_invalid=0, invalid_cnt=0, operand registers=0, req_ready=0.
REQ-029 Reset asserted mid-CALC or mid-HOLD SHALL discard the in-flight result, with no handoff and no count.
REQ-030 The first grant after reset release SHALL occur on the first rising edge with rst low and any req_valid set.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE/CALC/HOLD), the FP32 width constant 32, and the counter width 16.
REQ-032 SHALL instantiate exactly one existing Multiplier sub-module (combinational; ports A, B, En, Out, Invalid_Num), driven from the operand registers.
REQ-033 The round-robin picker SHALL be a combinational function inside mult_arbiter, not a separate module.

Verification
REQ-034 Requester 0 with A=0x40000000 (2.0), B=0x40400000 (3.0), out_ready=1 -> out_data=0x40C00000, out_id=0, out_invalid=0, and out_valid exactly 2 cycles after the grant.
REQ-035 All 4 req_valid held high with out_ready=1 -> grants in order 0,1,2,3,0, one every 2 cycles, with out_id matching each grant.
REQ-036 A=0x7FC00000 (NaN), B=0x3F800000 (1.0) -> out_invalid=1, and invalid_cnt goes 0 -> 1 at the handoff.
REQ-037 out_ready held low 5 cycles in HOLD with other requests pending -> out_data and out_id stable, req_ready=0 throughout, then a grant on the cycle out_ready rises.
REQ-038 rst pulsed during CALC -> out_valid=0, rr_ptr=0 and invalid_cnt=0 immediately, and requester 0 is granted first after release.
REQ-039 Forced invalid_cnt=0xFFFF plus one more NaN handoff -> invalid_cnt stays 0xFFFF.

Source files
------------

// File: rtl/mult_arbiter_pkg.sv
// mult_arbiter_pkg: shared FSM state, FP32 width and counter width for the multiplier arbiter
package mult_arbiter_pkg;
   localparam int FPW = 32;
   localparam int CNTW = 16;
   localparam logic [FPW-1:0] QNAN = 32'h7FC00000;
   typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
endpackage

// File: rtl/Multiplier.sv
// Multiplier: combinational FP32 multiply, round-to-nearest-even, subnormals flushed to zero
module Multiplier
   import mult_arbiter_pkg::*;
(
   input  logic [FPW-1:0] A,
   input  logic [FPW-1:0] B,
   input  logic           En,
   output logic [FPW-1:0] Out,
   output logic           Invalid_Num
);
   logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, sign, norm, rnd, carry;
   logic [47:0] prod;
   logic [22:0] frac;
   logic [23:0] frac_r;
   logic signed [9:0] exp_s;
   assign nan_a = (&A[30:23]) && (|A[22:0]);
   assign nan_b = (&B[30:23]) && (|B[22:0]);
   assign inf_a = (&A[30:23]) && !(|A[22:0]);
   assign inf_b = (&B[30:23]) && !(|B[22:0]);
   assign zero_a = !(|A[30:23]);
   assign zero_b = !(|B[30:23]);
   assign sign = A[31] ^ B[31];
   assign prod = {24'(!zero_a) << 23 | 24'(A[22:0])} * {24'(!zero_b) << 23 | 24'(B[22:0])};
   assign norm = prod[47];
   assign frac = norm ? prod[46:24] : prod[45:23];
   assign rnd = norm ? prod[23] & ((|prod[22:0]) | prod[24]) : prod[22] & ((|prod[21:0]) | prod[23]);
   assign frac_r = {1'b0, frac} + 24'(rnd);
   assign carry = frac_r[23];
   // a rounding carry leaves the fraction all-zero and bumps the exponent
   assign exp_s = $signed({2'b0, A[30:23]}) + $signed({2'b0, B[30:23]}) - 10'sd127
                + $signed({9'b0, norm}) + $signed({9'b0, carry});
   assign Invalid_Num = En & (nan_a | nan_b | inf_a | inf_b);
   always_comb begin
      Out = '0;
      if (En)
         Out = (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) ? QNAN :
               (inf_a || inf_b || exp_s >= 10'sd255)                      ? {sign, 8'hFF, 23'h0} :
               (zero_a || zero_b || exp_s <= 10'sd0)                      ? {sign, 31'h0} :
                                                                            {sign, exp_s[7:0], frac_r[22:0]};
   end
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one FP32 multiplier among NREQ requesters
module mult_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW = 2
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [FPW*NREQ-1:0] req_a,
   input  logic [FPW*NREQ-1:0] req_b,
   output logic [NREQ-1:0]     req_ready,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [FPW-1:0]      out_data,
   output logic [IDW-1:0]      out_id,
   output logic                out_invalid,
   output logic [CNTW-1:0]     invalid_cnt
);
   state_t state;
   logic [IDW-1:0] rr_ptr, op_id, gnt_id;
   logic [FPW-1:0] op_a, op_b, mul_out;
   logic [IDW:0] pick;
   logic grant, mul_inv, mul_en;
   // returns {found, index}; lowest offset from ptr wins because it is assigned last
   function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] ptr);
      rr_pick = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         int j;
         j = (int'(ptr) + i) % NREQ;
         if (v[j]) rr_pick = {1'b1, IDW'(j)};
      end
   endfunction
   assign pick = rr_pick(req_valid, rr_ptr);
   assign gnt_id = pick[IDW-1:0];
   assign grant = pick[IDW] && (state == IDLE || (state == HOLD && out_ready));
   assign req_ready = (grant && !rst) ? NREQ'(1) << gnt_id : '0;
   assign mul_en = (state == CALC);
   Multiplier u_mul (
      .A(op_a),
      .B(op_b),
      .En(mul_en),
      .Out(mul_out),
      .Invalid_Num(mul_inv)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         rr_ptr <= '0;
         op_a <= '0;
         op_b <= '0;
         op_id <= '0;
         out_valid <= 1'b0;
         out_data <= '0;
         out_id <= '0;
         out_invalid <= 1'b0;
         invalid_cnt <= '0;
      end else begin
         if (grant) begin
            op_a <= req_a[32'(gnt_id)*FPW +: FPW];
            op_b <= req_b[32'(gnt_id)*FPW +: FPW];
            op_id <= gnt_id;
            rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
         end
         if (out_valid && out_ready && out_invalid && invalid_cnt != '1)
            invalid_cnt <= invalid_cnt + 1'b1;
         case (state)
            IDLE: if (grant) state <= CALC;
            CALC: begin
               out_data <= mul_out;
               out_invalid <= mul_inv;
               out_id <= op_id;
               out_valid <= 1'b1;
               state <= HOLD;
            end
            HOLD: if (out_ready) begin
               out_valid <= 1'b0;
               state <= grant ? CALC : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
